// File: rtl/seq_gen_pkg.sv
// Shared definitions for the serial pattern generator.
//   state_e   : FSM encoding, also driven out on the debug 'state' port
//   DEF_WIDTH : default maximum pattern length in bits
//   DEF_RW    : default width of the extra-repetition count
package seq_gen_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_RW    = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    SHIFT  = 2'b01,
    PARITY = 2'b10,
    DONE   = 2'b11
  } state_e;

endpackage

// File: rtl/seq_gen_if.sv
// Request/serial-output bundle of the pattern generator.
//   master : drives start/pattern/len/repeat_cnt, observes x/x_valid/busy/done/state
//   slave  : the generator side
import seq_gen_pkg::*;

interface seq_gen_if #(
  parameter int WIDTH = DEF_WIDTH,
  parameter int RW    = DEF_RW,
  parameter int LW    = $clog2(WIDTH + 1)
);
  logic             start;
  logic [WIDTH-1:0] pattern;
  logic [LW-1:0]    len;
  logic [RW-1:0]    repeat_cnt;
  logic             x;
  logic             x_valid;
  logic             busy;
  logic             done;
  logic [1:0]       state;

  modport master (
    output start, pattern, len, repeat_cnt,
    input  x, x_valid, busy, done, state
  );

  modport slave (
    input  start, pattern, len, repeat_cnt,
    output x, x_valid, busy, done, state
  );
endinterface

// File: rtl/seq_gen_shifter.sv
// MSB-first shift register with a bit down-counter.
// The caller presents the first bit of a repetition itself; this block holds
// the remaining bits (load_tail) and hands out the following bit on next_bit.
//   clk, reset_n : clock, async active-low reset (counter only)
//   load         : load load_tail and load_cnt (start of a repetition)
//   shift        : advance by one bit, count down
//   load_tail    : pattern bits after the first one, left aligned
//   load_cnt     : bits in the repetition minus one
//   next_bit     : bit that follows the one currently on x
//   last         : the bit currently on x is the last of the repetition
import seq_gen_pkg::*;

module seq_gen_shifter #(
  parameter int WIDTH = DEF_WIDTH,
  parameter int LW    = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-2:0] load_tail,
  input  logic [LW-1:0]    load_cnt,
  output logic             next_bit,
  output logic             last
);

  logic [WIDTH-1:0] sr_q, sr_d;
  logic [LW-1:0]    cnt_q, cnt_d;

  always_comb begin
    sr_d  = sr_q;
    cnt_d = cnt_q;
    if (load) begin
      sr_d  = {load_tail, 1'b0};
      cnt_d = load_cnt;
    end else if (shift) begin
      sr_d  = {sr_q[WIDTH-2:0], 1'b0};
      cnt_d = cnt_q - LW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

  // Pattern bits are pure data and need no reset.
  always_ff @(posedge clk) begin
    sr_q <= sr_d;
  end

  assign next_bit = sr_q[WIDTH-1];
  assign last     = (cnt_q == '0);

endmodule

// File: rtl/seq_pattern_gen.sv
// Serial bit-pattern transmitter. On start (while idle) captures pattern, len
// and repeat_cnt, then sends pattern[len-1..0] MSB-first on x, repeated
// repeat_cnt extra times back-to-back, followed by a one-cycle done pulse.
// Optional build macro SEQ_GEN_PARITY_EN appends an even-parity bit after each
// repetition.
//   clk     : rising-edge clock
//   reset_n : asynchronous active-low reset
//   bus     : seq_gen_if slave (start/pattern/len/repeat_cnt in,
//             x/x_valid/busy/done/state out, all outputs registered)
import seq_gen_pkg::*;

module seq_pattern_gen #(
  parameter int WIDTH = DEF_WIDTH,
  parameter int RW    = DEF_RW,
  parameter int LW    = $clog2(WIDTH + 1)
) (
  input  logic      clk,
  input  logic      reset_n,
  seq_gen_if.slave  bus
);

  state_e           state_q, state_d;
  logic             x_q, x_d;
  logic             x_valid_q, x_valid_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [RW-1:0]    rep_q, rep_d;
  logic [WIDTH-1:0] pat_q, pat_d;
  logic [LW-1:0]    len_q, len_d;
`ifdef SEQ_GEN_PARITY_EN
  logic             par_q, par_d;
`endif

  logic [LW-1:0]    len_eff;
  logic [WIDTH-1:0] pat_aligned;
  logic             sh_load, sh_shift, sh_next_bit, sh_last;
  logic [WIDTH-2:0] sh_tail;
  logic [LW-1:0]    sh_cnt;
  logic             rep_end;

  // Out-of-range lengths fall back to the full width; the pattern is then
  // left-aligned so pattern[len-1] sits in the MSB and shifts out first.
  assign len_eff     = (bus.len == '0 || bus.len > LW'(WIDTH)) ? LW'(WIDTH) : bus.len;
  assign pat_aligned = bus.pattern << (LW'(WIDTH) - len_eff);

  seq_gen_shifter #(.WIDTH(WIDTH), .LW(LW)) u_shifter (
    .clk       (clk),
    .reset_n   (reset_n),
    .load      (sh_load),
    .shift     (sh_shift),
    .load_tail (sh_tail),
    .load_cnt  (sh_cnt),
    .next_bit  (sh_next_bit),
    .last      (sh_last)
  );

  always_comb begin
    state_d   = state_q;
    x_d       = 1'b0;
    x_valid_d = 1'b0;
    done_d    = 1'b0;
    pat_d     = pat_q;
    len_d     = len_q;
    rep_d     = rep_q;
    sh_load   = 1'b0;
    sh_shift  = 1'b0;
    sh_tail   = pat_q[WIDTH-2:0];
    sh_cnt    = len_q - LW'(1);
    rep_end   = 1'b0;
`ifdef SEQ_GEN_PARITY_EN
    par_d     = par_q;
`endif

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          pat_d     = pat_aligned;
          len_d     = len_eff;
          rep_d     = bus.repeat_cnt;
          sh_load   = 1'b1;
          sh_tail   = pat_aligned[WIDTH-2:0];
          sh_cnt    = len_eff - LW'(1);
          x_d       = pat_aligned[WIDTH-1];
          x_valid_d = 1'b1;
          state_d   = SHIFT;
`ifdef SEQ_GEN_PARITY_EN
          par_d     = 1'b0;
`endif
        end
      end
      SHIFT: begin
`ifdef SEQ_GEN_PARITY_EN
        par_d = par_q ^ x_q;
`endif
        if (!sh_last) begin
          sh_shift  = 1'b1;
          x_d       = sh_next_bit;
          x_valid_d = 1'b1;
        end else begin
`ifdef SEQ_GEN_PARITY_EN
          // Parity includes the bit on x right now (the last one).
          state_d   = PARITY;
          x_d       = par_q ^ x_q;
          x_valid_d = 1'b1;
`else
          rep_end   = 1'b1;
`endif
        end
      end
`ifdef SEQ_GEN_PARITY_EN
      PARITY: rep_end = 1'b1;
`endif
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // End of a repetition: reload for the next one with no gap, or finish.
    if (rep_end) begin
      if (rep_q != '0) begin
        rep_d     = rep_q - RW'(1);
        sh_load   = 1'b1;
        x_d       = pat_q[WIDTH-1];
        x_valid_d = 1'b1;
        state_d   = SHIFT;
`ifdef SEQ_GEN_PARITY_EN
        par_d     = 1'b0;
`endif
      end else begin
        state_d = DONE;
        done_d  = 1'b1;
      end
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      x_q       <= 1'b0;
      x_valid_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      rep_q     <= '0;
`ifdef SEQ_GEN_PARITY_EN
      par_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      x_q       <= x_d;
      x_valid_q <= x_valid_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      rep_q     <= rep_d;
`ifdef SEQ_GEN_PARITY_EN
      par_q     <= par_d;
`endif
    end
  end

  // Shadow copies of the request are data only.
  always_ff @(posedge clk) begin
    pat_q <= pat_d;
    len_q <= len_d;
  end

  assign bus.x       = x_q;
  assign bus.x_valid = x_valid_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.state   = state_q;

endmodule
